// File: rtl/fwd_net.sv
// fwd_net: operand forwarding network with load-use stall detection over an NSTG-deep tag pipeline.
// Optional stall-cycle counter enabled by defining FWD_NET_PERF_CNT_EN.
module fwd_net #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int NSTG = 3,
  localparam int LW = (NSTG > 1) ? $clog2(NSTG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [AW-1:0]     issue_waddr,
  input  logic [LW-1:0]     issue_lat,
  input  logic              pipe_hold,
  input  logic              flush,
  input  logic [NSTG*DW-1:0] stg_data,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NRD*DW-1:0] rf_data,
  output logic [NRD*DW-1:0] fwd_data,
  output logic              stall,
  output logic [31:0]       stall_cnt
);
  logic [NSTG-1:0]         v;
  logic [NSTG-1:0][AW-1:0] wa;
  logic [NSTG-1:0][LW-1:0] lat;
  logic [NRD-1:0]          hit, nrdy;
  logic [LW-1:0]           win [NRD];
  logic [LW-1:0]           lat_c;
  assign lat_c = ({1'b0, issue_lat} >= (LW+1)'(NSTG)) ? LW'(NSTG-1) : issue_lat;
  // Scan oldest to youngest so the youngest matching producer overwrites the selection.
  always_comb begin
    hit = '0;
    nrdy = '0;
    fwd_data = rf_data;
    for (int p = 0; p < NRD; p++) begin
      win[p] = '0;
      for (int k = NSTG-1; k >= 0; k--)
        if (v[k] && wa[k] == rd_addr[p*AW +: AW] && rd_addr[p*AW +: AW] != '0) begin
          hit[p] = 1'b1;
          win[p] = LW'(k);
        end
      nrdy[p] = hit[p] && (win[p] < lat[win[p]]);
      if (hit[p] && !nrdy[p]) fwd_data[p*DW +: DW] = stg_data[int'(win[p])*DW +: DW];
    end
  end
  assign stall = |nrdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      wa <= '0;
      lat <= '0;
    end else if (flush) begin
      v <= '0;
    end else if (!pipe_hold) begin
      v <= {v[NSTG-2:0], issue_valid & issue_wr & ~stall};
      wa <= {wa[NSTG-2:0], issue_waddr};
      lat <= {lat[NSTG-2:0], lat_c};
    end
`ifdef FWD_NET_PERF_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (stall && !pipe_hold && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
  assign stall_cnt = cnt;
`else
  assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_fwd_net.sv
// tb_fwd_net: directed self-checking bench for fwd_net (NSTG=3, NRD=2).
module tb_fwd_net;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wr, pipe_hold, flush;
  logic [4:0]  issue_waddr;
  logic [1:0]  issue_lat;
  logic [95:0] stg_data;
  logic [9:0]  rd_addr;
  logic [63:0] rf_data;
  logic [63:0] fwd_data;
  logic        stall;
  logic [31:0] stall_cnt;
  int pass = 0, total = 0;
  logic [31:0] exp_cnt = 0;
  fwd_net dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_waddr(issue_waddr), .issue_lat(issue_lat), .pipe_hold(pipe_hold), .flush(flush),
    .stg_data(stg_data), .rd_addr(rd_addr), .rf_data(rf_data), .fwd_data(fwd_data),
    .stall(stall), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] a, input logic [1:0] l);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_waddr = a; issue_lat = l; rd_addr = '0;
    tick();
    issue_valid = 1'b0;
  endtask
  task automatic drain();
    issue_valid = 1'b0; rd_addr = '0;
    repeat (3) tick();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    rf_data = {32'hBBBB_0001, 32'hAAAA_0000}; rd_addr = {5'd6, 5'd5};
    repeat (2) tick();
    #1;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass++;
    total++; if (fwd_data !== rf_data) $display("FAIL reset_fwd got %h exp %h", fwd_data, rf_data); else pass++;
    total++; if (stall_cnt !== 32'd0) $display("FAIL reset_cnt got %0d exp 0", stall_cnt); else pass++;
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_lat0();
    issue(5'd5, 2'd0);
    rd_addr = {5'd7, 5'd5}; stg_data[31:0] = 32'h1234; rf_data = {32'h7777, 32'h5555};
    #1;
    total++; if (fwd_data[31:0] !== 32'h1234) $display("FAIL lat0_fwd got %h exp 00001234", fwd_data[31:0]); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL lat0_stall got %b exp 0", stall); else pass++;
    total++; if (fwd_data[63:32] !== 32'h7777) $display("FAIL lat0_port1_rf got %h exp 00007777", fwd_data[63:32]); else pass++;
    drain();
  endtask
  task automatic test_load_use();
    issue(5'd8, 2'd1);
    rd_addr = {5'd0, 5'd8}; rf_data = {32'h9999, 32'h8888}; stg_data = {32'h0, 32'hABCD, 32'hDEAD};
    issue_valid = 1'b1; issue_wr = 1'b1; issue_waddr = 5'd9; issue_lat = 2'd0;
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", stall); else pass++;
    total++; if (fwd_data[31:0] !== 32'h8888) $display("FAIL lu_fwd_rf got %h exp 00008888", fwd_data[31:0]); else pass++;
    tick();
`ifdef FWD_NET_PERF_CNT_EN
    exp_cnt++;
`endif
    issue_valid = 1'b0; rd_addr = {5'd9, 5'd8};
    #1;
    total++; if (stall !== 1'b0) $display("FAIL lu_release got %b exp 0", stall); else pass++;
    total++; if (fwd_data[31:0] !== 32'hABCD) $display("FAIL lu_fwd_stg1 got %h exp 0000abcd", fwd_data[31:0]); else pass++;
    total++; if (fwd_data[63:32] !== 32'h9999) $display("FAIL lu_bubble got %h exp 00009999", fwd_data[63:32]); else pass++;
    total++; if (stall_cnt !== exp_cnt) $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass++;
    drain();
  endtask
  task automatic test_youngest();
    issue(5'd3, 2'd0);
    issue(5'd3, 2'd0);
    rd_addr = {5'd3, 5'd3}; stg_data = {32'h333, 32'h222, 32'h111}; rf_data = {32'h1, 32'h0};
    #1;
    total++; if (fwd_data[31:0] !== 32'h111) $display("FAIL young_p0 got %h exp 00000111", fwd_data[31:0]); else pass++;
    total++; if (fwd_data[63:32] !== 32'h111) $display("FAIL young_p1 got %h exp 00000111", fwd_data[63:32]); else pass++;
    drain();
  endtask
  task automatic test_r0();
    issue(5'd0, 2'd0);
    issue(5'd0, 2'd2);
    rd_addr = {5'd0, 5'd0}; stg_data = {32'hFFFF, 32'hFFFF, 32'hFFFF}; rf_data = '0;
    #1;
    total++; if (fwd_data !== 64'd0) $display("FAIL r0_fwd got %h exp 0", fwd_data); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL r0_stall got %b exp 0", stall); else pass++;
    drain();
  endtask
  task automatic test_clamp();
    stg_data = {32'hC0DE, 32'h0, 32'h0}; rf_data = {32'h0, 32'h6666};
    issue(5'd6, 2'd3);
    rd_addr = {5'd0, 5'd6};
    #1;
    total++; if (stall !== 1'b1) $display("FAIL clamp_k0 got %b exp 1", stall); else pass++;
    rd_addr = '0;
    tick();
    rd_addr = {5'd0, 5'd6};
    #1;
    total++; if (stall !== 1'b1) $display("FAIL clamp_k1 got %b exp 1", stall); else pass++;
    rd_addr = '0;
    tick();
    rd_addr = {5'd0, 5'd6};
    #1;
    total++; if (stall !== 1'b0) $display("FAIL clamp_k2_stall got %b exp 0", stall); else pass++;
    total++; if (fwd_data[31:0] !== 32'hC0DE) $display("FAIL clamp_k2_fwd got %h exp 0000c0de", fwd_data[31:0]); else pass++;
    drain();
  endtask
  task automatic test_hold();
    issue(5'd8, 2'd1);
    rd_addr = {5'd0, 5'd8}; stg_data = {32'h0, 32'h4242, 32'h0}; rf_data = {32'h0, 32'h8080};
    issue_valid = 1'b1; issue_wr = 1'b1; issue_waddr = 5'd10; issue_lat = 2'd0; pipe_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (stall !== 1'b1) $display("FAIL hold_stall_%0d got %b exp 1", i, stall); else pass++;
      tick();
    end
    total++; if (stall_cnt !== exp_cnt) $display("FAIL hold_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass++;
    pipe_hold = 1'b0;
    tick();
`ifdef FWD_NET_PERF_CNT_EN
    exp_cnt++;
`endif
    issue_valid = 1'b0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL hold_release got %b exp 0", stall); else pass++;
    total++; if (fwd_data[31:0] !== 32'h4242) $display("FAIL hold_fwd got %h exp 00004242", fwd_data[31:0]); else pass++;
    total++; if (stall_cnt !== exp_cnt) $display("FAIL hold_cnt_after got %0d exp %0d", stall_cnt, exp_cnt); else pass++;
    drain();
  endtask
  task automatic test_flush();
    issue(5'd1, 2'd2);
    issue(5'd2, 2'd2);
    issue(5'd3, 2'd2);
    rd_addr = {5'd0, 5'd3};
    #1;
    total++; if (stall !== 1'b1) $display("FAIL flush_pre_stall got %b exp 1", stall); else pass++;
    flush = 1'b1; pipe_hold = 1'b1;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_waddr = 5'd4; issue_lat = 2'd0;
    tick();
    flush = 1'b0; pipe_hold = 1'b0; issue_valid = 1'b0;
    rf_data = {32'hF2F2, 32'hF1F1}; stg_data = {32'hEEEE, 32'hDDDD, 32'hCCCC};
    rd_addr = {5'd4, 5'd1};
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall); else pass++;
    total++; if (fwd_data !== rf_data) $display("FAIL flush_fwd got %h exp %h", fwd_data, rf_data); else pass++;
    total++; if (stall_cnt !== exp_cnt) $display("FAIL flush_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass++;
    rd_addr = {5'd3, 5'd2};
    #1;
    total++; if (fwd_data !== rf_data) $display("FAIL flush_fwd2 got %h exp %h", fwd_data, rf_data); else pass++;
    drain();
  endtask
  task automatic test_reset_mid();
    issue(5'd1, 2'd0);
    issue(5'd2, 2'd0);
    issue(5'd3, 2'd0);
    rd_addr = {5'd2, 5'd1}; rf_data = {32'h2222, 32'h1111}; stg_data = {32'hAAAA, 32'hBBBB, 32'hCCCC};
    #1;
    total++; if (fwd_data[31:0] !== 32'hAAAA) $display("FAIL mid_pre_fwd got %h exp 0000aaaa", fwd_data[31:0]); else pass++;
    #1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    total++; if (fwd_data !== rf_data) $display("FAIL mid_rst_fwd got %h exp %h", fwd_data, rf_data); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL mid_rst_stall got %b exp 0", stall); else pass++;
    total++; if (stall_cnt !== exp_cnt) $display("FAIL mid_rst_cnt got %0d exp %0d", stall_cnt, exp_cnt); else pass++;
    tick();
    rst_n = 1'b1;
    rd_addr = {5'd3, 5'd2};
    #1;
    total++; if (fwd_data !== {32'h2222, 32'h2222} && fwd_data !== rf_data) $display("FAIL mid_post_fwd got %h exp %h", fwd_data, rf_data); else pass++;
  endtask
  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; issue_waddr = '0; issue_lat = '0;
    pipe_hold = 1'b0; flush = 1'b0; stg_data = '0; rd_addr = '0; rf_data = '0;
    test_reset();
    test_lat0();
    test_load_use();
    test_youngest();
    test_r0();
    test_clamp();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/fwd_net.md
FWD_NET -- requirements
Module: fwd_net

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning datapath word width.
REQ-002 The block SHALL have parameter AW, default 5, meaning register-address width.
REQ-003 The block SHALL have parameter NRD, default 2, meaning number of operand read ports.
REQ-004 The block SHALL have parameter NSTG, default 3 (EX, MEM1, MEM2), meaning tracked producer stages, 2..8; LW = clog2(NSTG).
REQ-005 The block SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port issue_valid  in  1  an instruction leaves decode this cycle.
REQ-008 The block SHALL have port issue_wr  in  1  that instruction writes a register.
REQ-009 The block SHALL have port issue_waddr  in  AW  destination register.
REQ-010 The block SHALL have port issue_lat  in  LW  first stage index (0 = EX) at which the result is valid.
REQ-011 The block SHALL have port pipe_hold  in  1  external freeze, e.g. cache miss.
REQ-012 The block SHALL have port flush  in  1  kill all in-flight entries.
REQ-013 The block SHALL have port stg_data  in  NSTG*DW  result bus of stage k in slice k.
REQ-014 The block SHALL have port rd_addr  in  NRD*AW  source register of port p.
REQ-015 The block SHALL have port rf_data  in  NRD*DW  register-file read data of port p.
REQ-016 The block SHALL have port fwd_data  out  NRD*DW  bypassed operand of port p.
REQ-017 The block SHALL have port stall  out  1  operand not yet available; decode must not issue.
REQ-018 The block SHALL have port stall_cnt  out  32  stall-cycle count (see Configuration).

Function
REQ-019 The block SHALL keep an NSTG-entry tag pipeline; entry k holds {v, waddr, lat}.
REQ-020 On each clk edge with pipe_hold=0, entry k SHALL take entry k-1 for k>=1.
REQ-021 On each clk edge with pipe_hold=0, entry 0 SHALL take {issue_valid & issue_wr & ~stall, issue_waddr, issue_lat}; a stalled issue becomes a bubble (v=0).
REQ-022 With pipe_hold=1, all entries SHALL hold; stall and fwd_data remain combinationally valid.
REQ-023 Entry k SHALL match port p when v=1, waddr=rd_addr[p], and rd_addr[p]!=0; r0 never matches.
REQ-024 Among matches, the lowest k (youngest) SHALL win.
REQ-025 If the winner has k>=lat, fwd_data[p] SHALL be stg_data[k]; if no match, fwd_data[p] SHALL be rf_data[p].
REQ-026 If the winner has k<lat, port p SHALL be not-ready, and fwd_data[p] SHALL be rf_data[p].
REQ-027 stall SHALL be the OR of not-ready over all ports, combinational, with zero added latency.
REQ-028 issue_lat>=NSTG SHALL be clamped to NSTG-1 on capture.
REQ-029 flush SHALL clear every entry's v on the edge; flush overrides issue and pipe_hold.

Reset
REQ-030 With rst_n=0, all entry v bits SHALL clear asynchronously; waddr and lat SHALL clear to 0.
REQ-031 With rst_n=0, stall SHALL be 0 and fwd_data SHALL equal rf_data.
REQ-032 With rst_n=0, stall_cnt SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight entries, with no forwarding from pre-reset state.

Configuration
REQ-034 With macro FWD_NET_PERF_CNT_EN defined, stall_cnt SHALL increment on every edge where stall=1 and pipe_hold=0, saturate at 32'hFFFFFFFF, and not be cleared by flush.
REQ-035 Without FWD_NET_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter register shall exist.

Verification (NSTG=3, NRD=2)
REQ-036 Bench SHALL cover: issue r5 with lat=0; next cycle rd_addr[0]=5, stg_data[0]=32'h1234 -> fwd_data[0]=32'h1234, stall=0.
REQ-037 Bench SHALL cover: load r8 with lat=1; next cycle read r8 -> stall=1, bubble inserted; following cycle fwd_data = stg_data[1], stall=0.
REQ-038 Bench SHALL cover: r3 issued twice on consecutive cycles (both lat=0); read r3 -> stg_data[0] selected, not stg_data[1].
REQ-039 Bench SHALL cover: r0 written with lat=0, then read r0 with rf_data=0 -> fwd_data=0, stall=0.
REQ-040 Bench SHALL cover: pipe_hold=1 for 4 cycles during a load-use stall -> stall=1 throughout; stall_cnt +1 only after hold releases (macro on), stall_cnt=0 (macro off).
REQ-041 Bench SHALL cover: flush or rst_n=0 with 3 entries valid -> next read of any address returns rf_data, stall=0.
